// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty/almost-empty flag and fill-level controller for the dual-clock FIFO.
// Define RPTR_UNDERFLOW_EN to add the sticky rerr underflow flag.
module rptr_empty_ctrl #(
  parameter int unsigned ADDRSIZE      = 6,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
`ifdef RPTR_UNDERFLOW_EN
  output logic                rerr,
`endif
  output logic [ADDRSIZE:0]   rlevel
);

  localparam logic [ADDRSIZE:0] AEmptyThresh = AEMPTY_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rgray_d;
  logic [ADDRSIZE:0] rlevel_q, level_d;
  logic [ADDRSIZE:0] wbin_s;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic              rd_ok;

  assign rd_ok   = rinc & ~rempty_q;
  assign rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, rd_ok};
  assign rgray_d = (rbin_d >> 1) ^ rbin_d;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= int'(ADDRSIZE); i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
  end

  // Full-width compare keeps "same low bits, different MSB" as full rather than empty.
  assign rempty_d  = (rgray_d == rq2_wptr);
  assign level_d   = wbin_s - rbin_d;
  assign raempty_d = (level_d <= AEmptyThresh);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rgray_d;
      rlevel_q  <= level_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic rerr_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rerr_q <= 1'b0;
    end else if (rinc && rempty_q) begin
      rerr_q <= 1'b1;
    end
  end

  assign rerr = rerr_q;
`endif

  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;

endmodule
